// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: FUNC codes, the R-type ALU op,
// the sequencer state encoding and the decoded operation classes.
package mdu_pkg;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;
   localparam logic [5:0] FUNC_MFHI  = 6'b010000;
   localparam logic [5:0] FUNC_MTHI  = 6'b010001;
   localparam logic [5:0] FUNC_MFLO  = 6'b010010;
   localparam logic [5:0] FUNC_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      MUL  = 4'd1,
      MULU = 4'd2,
      DIV  = 4'd3,
      DIVU = 4'd4,
      MFHI = 4'd5,
      MFLO = 4'd6,
      MTHI = 4'd7,
      MTLO = 4'd8
   } op_class_e;

   // Signed iterative ops take operand magnitudes and re-apply signs in FIX.
   function automatic logic op_is_signed(input op_class_e op);
      return (op == MUL) || (op == DIV);
   endfunction

endpackage

// File: rtl/mdu_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the MDU.
interface mdu_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       aluop;
   logic [5:0]       func;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             flush;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, aluop, func, srca, srcb, flush,
      input  busy, stall, result, result_valid, div_by_zero, hi, lo
   );

   modport slave (
      input  start, aluop, func, srca, srcb, flush,
      output busy, stall, result, result_valid, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mdu_muldiv_unit_op_decode.sv
// Combinational ALUOP/FUNC decode into an MDU operation class.
module mdu_op_decode
   import mdu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] func,
   output op_class_e  op
);

   // Non-R-type ops and unknown FUNC codes belong to the ALU path.
   always_comb begin
      op = NONE;
      if (aluop == ALUOP_RTYPE) begin
         case (func)
            FUNC_MULT:  op = MUL;
            FUNC_MULTU: op = MULU;
            FUNC_DIV:   op = DIV;
            FUNC_DIVU:  op = DIVU;
            FUNC_MFHI:  op = MFHI;
            FUNC_MFLO:  op = MFLO;
            FUNC_MTHI:  op = MTHI;
            FUNC_MTLO:  op = MTLO;
            default:    op = NONE;
         endcase
      end else begin
         op = NONE;
      end
   end

endmodule

// File: rtl/mdu_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Multiply is shift-add with a left-shifting multiplicand so the accumulator is
// always aligned; divide is restoring, one quotient bit per cycle.
// Optional build macro MDU_EARLY_OUT_EN: multiply leaves RUN as soon as the
// remaining multiplier bits are zero.
module mdu_muldiv_unit
   import mdu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic rst,
   mdu_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   op_class_e          op_s;
   state_e             state_r;
   logic               busy_r;
   logic               dbz_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] acc_r;     // product, or remainder in the low half
   logic [2*WIDTH-1:0] opb_r;     // shifted multiplicand, or divisor in the low half
   logic [WIDTH-1:0]   opa_r;     // multiplier, or dividend shifting into quotient
   logic               is_mul_r;
   logic               neg_r;     // product/quotient negation
   logic               sa_r;      // remainder takes the dividend sign
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic               sa_s;
   logic               sb_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic [2*WIDTH-1:0] mul_acc_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH:0]     div_diff_s;
   logic               div_ge_s;
   logic               early_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   result_s;
   logic               result_valid_s;

   mdu_op_decode u_op_decode (
      .aluop (bus.aluop),
      .func  (bus.func),
      .op    (op_s)
   );

`ifdef MDU_EARLY_OUT_EN
   assign early_s = is_mul_r && (opa_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
   assign early_s = 1'b0;
`endif

   // Operand magnitudes and sign flags for the op being presented.
   always_comb begin
      sa_s    = op_is_signed(op_s) & bus.srca[WIDTH-1];
      sb_s    = op_is_signed(op_s) & bus.srcb[WIDTH-1];
      mag_a_s = sa_s ? -bus.srca : bus.srca;
      mag_b_s = sb_s ? -bus.srcb : bus.srcb;
   end

   // One radix-2 step of each algorithm plus the sign fix-up of the final values.
   always_comb begin
      mul_acc_s   = acc_r + (opa_r[0] ? opb_r : {(2*WIDTH){1'b0}});
      div_shift_s = {acc_r[WIDTH-1:0], opa_r[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_r[WIDTH-1:0]};
      div_ge_s    = ~div_diff_s[WIDTH];
      prod_s      = neg_r ? -acc_r : acc_r;
      quo_s       = neg_r ? -opa_r : opa_r;
      rem_s       = sa_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
   end

   // MFHI/MFLO read port; only valid when the unit is free and not squashed.
   always_comb begin
      result_s       = {WIDTH{1'b0}};
      result_valid_s = 1'b0;
      if (bus.start && !bus.flush && !busy_r && (op_s == MFHI)) begin
         result_s       = hi_r;
         result_valid_s = 1'b1;
      end else if (bus.start && !bus.flush && !busy_r && (op_s == MFLO)) begin
         result_s       = lo_r;
         result_valid_s = 1'b1;
      end else begin
         result_s       = {WIDTH{1'b0}};
         result_valid_s = 1'b0;
      end
   end

   // Sequencer and datapath: accept in IDLE, iterate in RUN, write back in FIX.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         busy_r   <= 1'b0;
         dbz_r    <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {(2*WIDTH){1'b0}};
         opb_r    <= {(2*WIDTH){1'b0}};
         opa_r    <= {WIDTH{1'b0}};
         is_mul_r <= 1'b0;
         neg_r    <= 1'b0;
         sa_r     <= 1'b0;
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
      end else begin
         dbz_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  case (op_s)
                     MUL, MULU, DIV, DIVU: begin
                        if (((op_s == DIV) || (op_s == DIVU)) && (bus.srcb == {WIDTH{1'b0}})) begin
                           dbz_r <= 1'b1;
                        end else begin
                           acc_r    <= {(2*WIDTH){1'b0}};
                           opa_r    <= mag_a_s;
                           opb_r    <= {{WIDTH{1'b0}}, mag_b_s};
                           is_mul_r <= (op_s == MUL) || (op_s == MULU);
                           neg_r    <= sa_s ^ sb_s;
                           sa_r     <= sa_s;
                           cnt_r    <= CNT_INIT;
                           busy_r   <= 1'b1;
                           state_r  <= RUN;
                        end
                     end
                     MTHI:    hi_r <= bus.srca;
                     MTLO:    lo_r <= bus.srca;
                     default: state_r <= IDLE;
                  endcase
               end
            end
            RUN: begin
               if (bus.flush) begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
                  if (is_mul_r) begin
                     acc_r <= mul_acc_s;
                     opb_r <= opb_r << 1;
                     opa_r <= opa_r >> 1;
                  end else begin
                     acc_r <= {{WIDTH{1'b0}}, (div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0])};
                     opa_r <= {opa_r[WIDTH-2:0], div_ge_s};
                  end
                  if ((cnt_r == CNT_ONE) || early_s) begin
                     state_r <= FIX;
                  end
               end
            end
            FIX: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
               if (!bus.flush) begin
                  if (is_mul_r) begin
                     {hi_r, lo_r} <= prod_s;
                  end else begin
                     hi_r <= rem_s;
                     lo_r <= quo_s;
                  end
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy         = busy_r;
   assign bus.div_by_zero  = dbz_r;
   assign bus.hi           = hi_r;
   assign bus.lo           = lo_r;
   assign bus.stall        = bus.start & (op_s != NONE) & busy_r & ~bus.flush;
   assign bus.result       = result_s;
   assign bus.result_valid = result_valid_s;

endmodule

// File: tb/tb_mdu_muldiv_unit.sv
// Self-checking bench for mdu_muldiv_unit: directed plan vectors plus random
// MULT/MULTU/DIV/DIVU checked against a plain-arithmetic HI/LO model.
module tb_mdu_muldiv_unit;

   localparam int W = 32;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdu_if #(.WIDTH(W)) bus ();
   mdu_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] exp_hi = 32'd0;
   logic [W-1:0] exp_lo = 32'd0;

   task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1; bus.aluop = 2'b10; bus.func = f;
      bus.srca = a; bus.srcb = b; bus.flush = 1'b0;
   endtask

   task automatic idle_bus();
      bus.start = 1'b0; bus.aluop = 2'b00; bus.func = 6'd0;
      bus.srca = 32'd0; bus.srcb = 32'd0; bus.flush = 1'b0;
   endtask

   function automatic int exp_busy(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
      logic [W-1:0] m;
      int h;
`endif
      if (f == F_DIV || f == F_DIVU) return (b == 32'd0) ? 0 : W + 1;
`ifdef MDU_EARLY_OUT_EN
      m = (f == F_MULT && a[W-1]) ? (~a + 32'd1) : a;
      h = -1;
      for (int i = 0; i < W; i++) if (m[i]) h = i;
      return (h < 0) ? 2 : h + 2;
`else
      return W + 1;
`endif
   endfunction

   task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sp, sq, sr;
      longint unsigned up;
      case (f)
         F_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); {exp_hi, exp_lo} = sp; end
         F_MULTU: begin up = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = up; end
         F_DIV: if (b != 32'd0) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            exp_lo = sq[W-1:0]; exp_hi = sr[W-1:0];
         end
         F_DIVU: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      int n, eb;
      logic dbz, edbz;
      @(negedge clk); drive(f, a, b);
      @(negedge clk); idle_bus();
      dbz = bus.div_by_zero;
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
      model(f, a, b);
      eb = exp_busy(f, a, b);
      edbz = (f == F_DIV || f == F_DIVU) && (b == 32'd0);
      vectors++;
      if (n !== eb) begin miscompares++; $display("FAIL %s busy_cycles got %0d want %0d", name, n, eb); end
      vectors++;
      if (dbz !== edbz) begin miscompares++; $display("FAIL %s div_by_zero got %b want %b", name, dbz, edbz); end
      vectors++;
      if (bus.hi !== exp_hi) begin miscompares++; $display("FAIL %s hi got %h want %h (a=%h b=%h)", name, bus.hi, exp_hi, a, b); end
      vectors++;
      if (bus.lo !== exp_lo) begin miscompares++; $display("FAIL %s lo got %h want %h (a=%h b=%h)", name, bus.lo, exp_lo, a, b); end
   endtask

   task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
      @(negedge clk); drive(F_MTHI, h, 32'd0);
      @(negedge clk); drive(F_MTLO, l, 32'd0);
      @(negedge clk); idle_bus();
      exp_hi = h; exp_lo = l;
      vectors++;
      if (bus.hi !== h || bus.lo !== l) begin
         miscompares++; $display("FAIL mthi_mtlo got %h/%h want %h/%h", bus.hi, bus.lo, h, l);
      end
   endtask

   task automatic test_reset();
      idle_bus();
      rst = 1'b1; #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.div_by_zero !== 1'b0 || bus.stall !== 1'b0) begin
         miscompares++; $display("FAIL reset_ctrl got busy=%b dbz=%b stall=%b want 0/0/0", bus.busy, bus.div_by_zero, bus.stall);
      end
      vectors++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         miscompares++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.hi, bus.lo);
      end
      rst = 1'b1;
   endtask

   task automatic test_plan();
      logic [5:0]   pf [6] = '{F_MULT, F_MULTU, F_DIVU, F_DIV, F_DIV, F_DIV};
      logic [W-1:0] pa [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd5};
      logic [W-1:0] pb [6] = '{32'd7, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
      logic [W-1:0] ph [6] = '{32'hFFFFFFFF, 32'h00000001, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [W-1:0] pl [6] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
      for (int i = 0; i < 6; i++) begin
         run_op(pf[i], pa[i], pb[i], $sformatf("plan%0d", i));
         vectors++;
         if (bus.hi !== ph[i] || bus.lo !== pl[i]) begin
            miscompares++; $display("FAIL plan%0d_const got %h/%h want %h/%h", i, bus.hi, bus.lo, ph[i], pl[i]);
         end
      end
      @(negedge clk);
      vectors++;
      if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_pulse_width got %b want 0", bus.div_by_zero); end
   endtask

   task automatic test_random();
      logic [5:0] fl [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
      logic [W-1:0] a, b;
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : $urandom;
         b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 255)) : $urandom;
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         run_op(fl[$urandom_range(0, 3)], a, b, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_stall_mflo();
      int n;
      logic bad;
      @(negedge clk); drive(F_MULT, 32'd6, 32'd7);
      @(negedge clk); drive(F_MFLO, 32'd0, 32'd0);
      n = 0; bad = 1'b0;
      while (bus.busy === 1'b1 && n < 200) begin
         #1;
         if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) bad = 1'b1;
         n++;
         @(negedge clk);
      end
      #1;
      vectors++;
      if (bad) begin miscompares++; $display("FAIL stall_while_busy got stall/valid wrong want 1/0"); end
      vectors++;
      if (n !== exp_busy(F_MULT, 32'd6, 32'd7)) begin miscompares++; $display("FAIL stall_cycles got %0d want %0d", n, exp_busy(F_MULT, 32'd6, 32'd7)); end
      vectors++;
      if (bus.stall !== 1'b0 || bus.result !== 32'h2A || bus.result_valid !== 1'b1) begin
         miscompares++; $display("FAIL mflo_after_stall got stall=%b result=%h valid=%b want 0/0000002a/1", bus.stall, bus.result, bus.result_valid);
      end
      exp_hi = 32'd0; exp_lo = 32'd42;
      @(negedge clk); idle_bus();
   endtask

   task automatic test_flush();
      int n;
      write_hilo($urandom, $urandom);
      @(negedge clk); drive(F_DIV, 32'd100, 32'd3);
      @(negedge clk); idle_bus();
      n = 1;
      while (n < 10) begin @(negedge clk); n++; end
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL flush_pre_busy got %b want 1", bus.busy); end
      bus.flush = 1'b1;
      @(negedge clk); bus.flush = 1'b0;
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b want 0", bus.busy); end
      repeat (40) @(negedge clk);
      vectors++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
         miscompares++; $display("FAIL flush_hilo got %h/%h want %h/%h", bus.hi, bus.lo, exp_hi, exp_lo);
      end
      drive(F_DIVU, 32'd9, 32'd2); bus.flush = 1'b1;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", bus.stall); end
      @(negedge clk); drive(F_MTHI, ~exp_hi, 32'd0); bus.flush = 1'b1;
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle_start got busy=%b want 0", bus.busy); end
      @(negedge clk); idle_bus();
      vectors++;
      if (bus.hi !== exp_hi) begin miscompares++; $display("FAIL flush_mthi got %h want %h", bus.hi, exp_hi); end
   endtask

   task automatic test_reset_mid();
      write_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
      @(negedge clk); drive(F_MULT, $urandom, $urandom);
      @(negedge clk); idle_bus();
      repeat (5) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_busy got %b want 1", bus.busy); end
      rst = 1'b0;
      #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         miscompares++; $display("FAIL rstmid got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
      end
      @(negedge clk); rst = 1'b1;
      exp_hi = 32'd0; exp_lo = 32'd0;
   endtask

   task automatic test_move_read();
      logic [W-1:0] l;
      l = $urandom;
      write_hilo(32'h12345678, l);
      @(negedge clk); drive(F_MFHI, 32'd0, 32'd0); #1;
      vectors++;
      if (bus.result !== 32'h12345678 || bus.result_valid !== 1'b1) begin
         miscompares++; $display("FAIL mfhi got %h/%b want 12345678/1", bus.result, bus.result_valid);
      end
      drive(F_MFLO, 32'd0, 32'd0); #1;
      vectors++;
      if (bus.result !== l || bus.result_valid !== 1'b1) begin
         miscompares++; $display("FAIL mflo got %h/%b want %h/1", bus.result, bus.result_valid, l);
      end
      drive(F_MULT, 32'd3, 32'd3); bus.aluop = 2'b00; #1;
      vectors++;
      if (bus.result_valid !== 1'b0 || bus.result !== 32'd0) begin
         miscompares++; $display("FAIL non_rtype_read got %h/%b want 0/0", bus.result, bus.result_valid);
      end
      @(negedge clk); drive(6'b100000, 32'd3, 32'd3);
      @(negedge clk); idle_bus();
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'h12345678 || bus.lo !== l) begin
         miscompares++; $display("FAIL alu_path_ignored got busy=%b hi=%h lo=%h want 0/12345678/%h", bus.busy, bus.hi, bus.lo, l);
      end
      run_op(F_MULTU, 32'd3, 32'd5, "multu3x5");
   endtask

   task automatic test_back_to_back();
      int n;
      logic [W-1:0] a2, b2;
      a2 = $urandom; b2 = W'($urandom_range(1, 1000));
      @(negedge clk); drive(F_MULTU, $urandom, $urandom);
      @(negedge clk); drive(F_DIVU, a2, b2);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
      @(negedge clk); idle_bus();
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
      model(F_DIVU, a2, b2);
      vectors++;
      if (n !== W + 1) begin miscompares++; $display("FAIL b2b_busy got %0d want %0d", n, W + 1); end
      vectors++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
         miscompares++; $display("FAIL b2b_hilo got %h/%h want %h/%h", bus.hi, bus.lo, exp_hi, exp_lo);
      end
   endtask

   initial begin
      test_reset();
      test_plan();
      test_random();
      test_stall_mflo();
      test_flush();
      test_reset_mid();
      test_move_read();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdu_muldiv_unit.md
Name: mdu_muldiv_unit

Overview:
Parametrised multiply/divide unit for the EX stage. It decodes the R-type FUNC field for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and owns the architectural HI/LO registers. Multiply uses iterative shift-add and divide uses restoring division, each over WIDTH cycles. It sits beside the single-cycle ALU and stalls the pipeline through a STALL handshake while busy.

Parameters:
WIDTH, 32, operand/HI/LO width (even, >=8)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
START  in  1  EX-stage instruction valid
ALUOP  in  2  main-decoder ALU op; MDU acts only when 2'b10
FUNC  in  6  instruction funct field
SRCA  in  WIDTH  rs operand
SRCB  in  WIDTH  rt operand
FLUSH  in  1  abort in-flight op / squash current START
BUSY  out  1  iterative op in progress
STALL  out  1  hold pipeline (combinational)
RESULT  out  WIDTH  MFHI/MFLO read data (combinational)
RESULT_VALID  out  1  RESULT is meaningful this cycle
DIV_BY_ZERO  out  1  one-cycle pulse on divide with SRCB==0
HI  out  WIDTH  architectural HI
LO  out  WIDTH  architectural LO

Behaviour:
- Reset (RST low, async): HI=0, LO=0, state IDLE, BUSY=0, DIV_BY_ZERO=0, counter=0, all internal accumulators=0. Reset mid-operation discards the op.
- Decode is active only when START=1 and ALUOP=2'b10. FUNC codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO. Other FUNC values are ignored (ALU path).
- States: IDLE, RUN, FIX. BUSY=1 in RUN and FIX.
- IDLE + accepted MULT/DIV: latch operand magnitudes (signed ops: two's-complement abs; unsigned: raw) and sign flags; counter=WIDTH; go to RUN.
- RUN: one radix-2 step per cycle; counter decrements; at counter==1 go to FIX.
- FIX: apply signs. Product is negated if sA^sB. Quotient is negated if sA^sB; remainder takes the sign of sA. Write {HI,LO}=product for multiply, or HI=remainder, LO=quotient for divide. Go to IDLE.
- Latency: BUSY is high for exactly WIDTH+1 cycles after the accepting edge. HI/LO update on the FIX-exit edge.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): LO=-2^(WIDTH-1), HI=0, no flag.
- Divide by zero: no RUN; HI/LO unchanged; DIV_BY_ZERO pulses for the cycle after acceptance; BUSY stays 0.
- STALL = START & ALUOP==10 & (any MDU FUNC) & BUSY & !FLUSH. The stalled instruction is re-presented and accepted on the first cycle BUSY=0.
- MFHI/MFLO when not busy: RESULT=HI or LO in the same cycle, RESULT_VALID=1. Otherwise RESULT=0, RESULT_VALID=0.
- MTHI/MTLO when not busy: HI or LO is written with SRCA at the next edge.
- FLUSH: when asserted in RUN/FIX, return to IDLE at the next edge with HI/LO unchanged. FLUSH with START in IDLE means START is ignored. FLUSH wins over FIX write-back in the same cycle.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: in multiply RUN, if the remaining unshifted multiplier bits are all zero, jump directly to FIX with the accumulator correctly aligned. BUSY length becomes (index of highest set magnitude bit +1)+1, minimum 2 cycles. Divide is unaffected.
- Undefined: multiply always takes WIDTH+1 cycles.

Decomposition:
- Package mdu_pkg: FUNC code localparams, ALUOP_RTYPE=2'b10, state enum {IDLE,RUN,FIX}, op-class enum {NONE,MUL,MULU,DIV,DIVU,MFHI,MFLO,MTHI,MTLO}.
- One natural sub-module: mdu_op_decode, combinational ALUOP/FUNC to op class.
- Sequencing and datapath stay in the top.

Test Plan (WIDTH=32):
1. MULT SRCA=0xFFFFFFFD, SRCB=7 -> BUSY high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
2. MULTU 0xFFFFFFFF×2 -> HI=0x00000001, LO=0xFFFFFFFE. DIVU 7/2 -> LO=3, HI=1. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIV 5/0 -> DIV_BY_ZERO pulses 1 cycle, BUSY never high, HI/LO unchanged.
4. MFLO held 5 cycles after MULT 6×7 -> STALL=1 until BUSY falls; next cycle RESULT=0x0000002A, RESULT_VALID=1.
5. DIV 100/3 with FLUSH on the 10th RUN cycle -> IDLE next edge, HI/LO keep prior values. Separately, RST low mid-MULT -> HI=LO=0, BUSY=0 immediately.
6. MTHI 0x12345678 then MFHI -> RESULT=0x12345678. With MDU_EARLY_OUT_EN, MULTU 3×5 -> BUSY 3 cycles, LO=15.
